// File: rtl/ccd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : ccd_timing_gen
// Description : Linear-CCD frame timing generator (ICG gate + SH shutter pulses)
// Revision    : 1.0 - initial release
// ============================================================================
module ccd_timing_gen #(
    parameter int CNT_W = 16,
    parameter int LEAD  = 5,
    parameter int TAIL  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] cfg_sh_high,
    input  logic [CNT_W-1:0] cfg_sh_period,
    input  logic [7:0]       cfg_sh_count,
    output logic             sh,
    output logic             icg,
    output logic             frame_start,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEAD = 3'd1,
        S_SHP  = 3'd2,
        S_TAIL = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_LEAD_M1 = CNT_W'(LEAD - 1);
    localparam logic [CNT_W-1:0] C_TAIL_M1 = CNT_W'(TAIL - 1);
    localparam logic [CNT_W-1:0] C_TAIL_P1 = CNT_W'(TAIL + 1);
    localparam logic [CNT_W:0]   C_TAIL_P1_X = (CNT_W+1)'(TAIL + 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_pcnt;
    logic             r_first;
    logic [CNT_W-1:0] r_h_m1;
    logic [CNT_W-1:0] r_gapf_m1;
    logic [CNT_W-1:0] r_gap_m1;

    logic [CNT_W-1:0] w_h;
    logic [CNT_W:0]   w_pmin;
    logic [CNT_W-1:0] w_p;
    logic [7:0]       w_n_m1;
    logic             w_frame_end;
    logic             w_start;

    // Gap lengths are derived modulo 2^CNT_W; the true results always fit,
    // so an overflowing minimum period still yields the right phase lengths.
    always_comb begin
        w_h    = (cfg_sh_high == '0) ? C_ONE : cfg_sh_high;
        w_pmin = {1'b0, w_h} + C_TAIL_P1_X;
        w_p    = ({1'b0, cfg_sh_period} < w_pmin) ? w_pmin[CNT_W-1:0] : cfg_sh_period;
        w_n_m1 = (cfg_sh_count == 8'd0) ? 8'd0 : cfg_sh_count - 8'd1;
    end

    assign w_frame_end = (r_state == S_GAP) && (r_cnt == '0) && (r_pcnt == 8'd0);
    assign w_start     = enable && ((r_state == S_IDLE) || w_frame_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_pcnt      <= 8'd0;
            r_first     <= 1'b0;
            r_h_m1      <= '0;
            r_gapf_m1   <= '0;
            r_gap_m1    <= '0;
            sh          <= 1'b0;
            icg         <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (w_start) begin
                r_state     <= S_LEAD;
                r_cnt       <= C_LEAD_M1;
                r_pcnt      <= w_n_m1;
                r_first     <= 1'b1;
                r_h_m1      <= w_h - C_ONE;
                r_gapf_m1   <= w_p - w_h - C_TAIL_P1;
                r_gap_m1    <= w_p - w_h - C_ONE;
                sh          <= 1'b0;
                icg         <= 1'b0;
                frame_start <= 1'b1;
                busy        <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        busy <= 1'b0;
                    end
                    S_LEAD: begin
                        if (r_cnt == '0) begin
                            r_state <= S_SHP;
                            r_cnt   <= r_h_m1;
                            sh      <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    S_SHP: begin
                        if (r_cnt == '0) begin
                            sh <= 1'b0;
                            // Only the first pulse is followed by the ICG tail.
                            if (r_first) begin
                                r_state <= S_TAIL;
                                r_cnt   <= C_TAIL_M1;
                            end else begin
                                r_state <= S_GAP;
                                r_cnt   <= r_gap_m1;
                            end
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    S_TAIL: begin
                        if (r_cnt == '0) begin
                            r_state <= S_GAP;
                            r_cnt   <= r_gapf_m1;
                            r_first <= 1'b0;
                            icg     <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    S_GAP: begin
                        if (r_cnt == '0) begin
                            if (r_pcnt != 8'd0) begin
                                r_pcnt  <= r_pcnt - 8'd1;
                                r_state <= S_SHP;
                                r_cnt   <= r_h_m1;
                                sh      <= 1'b1;
                            end else begin
                                r_state <= S_IDLE;
                                busy    <= 1'b0;
                                icg     <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - C_ONE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        sh      <= 1'b0;
                        icg     <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ccd_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ccd_timing_gen
// Description : Directed self-checking bench for ccd_timing_gen
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_timing_gen;

    localparam int CW = 8;
    localparam int LD = 2;
    localparam int TL = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [CW-1:0] cfg_sh_high;
    logic [CW-1:0] cfg_sh_period;
    logic [7:0]    cfg_sh_count;
    logic          sh;
    logic          icg;
    logic          frame_start;
    logic          busy;

    int total = 0;
    int bad   = 0;

    ccd_timing_gen #(
        .CNT_W (CW),
        .LEAD  (LD),
        .TAIL  (TL)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .cfg_sh_high   (cfg_sh_high),
        .cfg_sh_period (cfg_sh_period),
        .cfg_sh_count  (cfg_sh_count),
        .sh            (sh),
        .icg           (icg),
        .frame_start   (frame_start),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " sh"}, sh, 0);
        chk({tag, " icg"}, icg, 1);
        chk({tag, " fs"}, frame_start, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    // Checks one frame against the closed-form timing, starting at t=0.
    // Optional actions at given t: period change, enable drop, reset assert.
    task automatic run_frame(input string name, input int h, input int p, input int n,
                             input int chg_t, input int new_p, input int drop_t, input int rst_t);
        int  f;
        logic exp_sh;
        logic exp_icg;
        f = LD + n * p;
        for (int t = 0; t < f; t++) begin
            exp_sh  = (t >= LD) && (((t - LD) % p) < h);
            exp_icg = !(t < LD + h + TL);
            chk($sformatf("%s sh t%0d", name, t), sh, exp_sh);
            chk($sformatf("%s icg t%0d", name, t), icg, exp_icg);
            chk($sformatf("%s fs t%0d", name, t), frame_start, (t == 0));
            chk($sformatf("%s busy t%0d", name, t), busy, 1);
            if (t == chg_t) cfg_sh_period = CW'(new_p);
            if (t == drop_t) enable = 1'b0;
            if (t == rst_t) rst_n = 1'b0;
            tick();
            if (t == rst_t) return;
        end
    endtask

    initial begin
        int cnt;
        rst_n         = 1'b0;
        enable        = 1'b0;
        cfg_sh_high   = 8'd4;
        cfg_sh_period = 8'd20;
        cfg_sh_count  = 8'd3;
        tick();
        tick();
        chk_idle("reset");
        rst_n = 1'b1;
        tick();
        chk_idle("idle_no_en");

        // Back-to-back frames: P change mid-frame, then restore, then enable drop at t30
        enable = 1'b1;
        tick();
        run_frame("basic", 4, 20, 3, 10, 30, -1, -1);
        run_frame("p30", 4, 30, 3, 5, 20, -1, -1);
        run_frame("drop", 4, 20, 3, -1, 0, 30, -1);
        chk_idle("after_drop");
        tick();
        chk_idle("after_drop2");

        // Clamping: H=0, P=2, N=0 -> H=1, P=5, N=1
        cfg_sh_high   = 8'd0;
        cfg_sh_period = 8'd2;
        cfg_sh_count  = 8'd0;
        enable        = 1'b1;
        tick();
        run_frame("clamp", 1, 5, 1, -1, 0, 0, -1);
        chk_idle("after_clamp");

        // Reset during the first SH pulse
        cfg_sh_high   = 8'd4;
        cfg_sh_period = 8'd20;
        cfg_sh_count  = 8'd3;
        enable        = 1'b1;
        tick();
        run_frame("pre_rst", 4, 20, 3, -1, 0, -1, 3);
        chk_idle("in_rst");
        rst_n = 1'b1;
        tick();
        run_frame("post_rst", 4, 20, 3, -1, 0, 0, -1);
        chk_idle("after_post_rst");

        // Long frame measured by frame_start spacing
        cfg_sh_high   = 8'd4;
        cfg_sh_period = 8'd255;
        cfg_sh_count  = 8'd255;
        enable        = 1'b1;
        tick();
        chk("large fs t0", frame_start, 1);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!frame_start && cnt < 70000);
        chk("large frame len", cnt, LD + 255 * 255);
        chk("large busy", busy, 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
